// File: rtl/fifo_pack_rd.sv
// fifo_pack_rd: read-side drain stage for the synchronous FIFO.
// Pops BITW-wide head words and packs PACK consecutive words into one
// BITW*PACK-wide word, presented on a valid/ready stream. The first word
// popped lands in the lowest lane.
//
// Build option: define FIFO_PACK_FLUSH_EN to add the flush input and the
// pk_keep lane-valid output, allowing a partial word to be emitted while
// the FIFO is empty.
module fifo_pack_rd #(
  parameter int unsigned BITW = 8,
  parameter int unsigned PACK = 4,
  localparam int unsigned CNTW = $clog2(PACK)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BITW-1:0]      fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic [BITW*PACK-1:0] pk_data,
  output logic                 pk_valid,
  input  logic                 pk_ready,
`ifdef FIFO_PACK_FLUSH_EN
  input  logic                 flush,
  output logic [PACK-1:0]      pk_keep,
`endif
  output logic [CNTW-1:0]      lane_idx
);

  localparam logic [CNTW-1:0] LastLane = CNTW'(PACK - 1);

  // Accumulator holds lanes 0..PACK-2; the top lane is taken straight from
  // fifo_data on the completing pop, so no extra cycle is spent on it.
  logic [BITW-1:0]      acc_q [PACK-1];
  logic [BITW-1:0]      acc_d [PACK-1];
  logic [BITW*PACK-1:0] data_q, data_d;
  logic [BITW*PACK-1:0] full_word;
  logic                 valid_q, valid_d;
  logic [CNTW-1:0]      lane_q, lane_d;
  logic                 last_lane;
  logic                 stall;

  assign last_lane = (lane_q == LastLane);
  // Only the completing pop needs the output register; earlier lanes may
  // keep filling while the consumer is stalled.
  assign stall     = last_lane && valid_q && !pk_ready;
  // Gated by reset so the FIFO is never drained while this stage is held.
  assign fifo_pop  = rst && !fifo_empty && !stall;

  // Assemble the completed word: accumulated lanes plus the current head word.
  always_comb begin
    full_word = '0;
    for (int i = 0; i < int'(PACK) - 1; i++) begin
      full_word[i*BITW +: BITW] = acc_q[i];
    end
    full_word[(PACK-1)*BITW +: BITW] = fifo_data;
  end

`ifdef FIFO_PACK_FLUSH_EN
  logic [BITW*PACK-1:0] flush_word;
  logic [PACK-1:0]      flush_keep;
  logic [PACK-1:0]      keep_q, keep_d;
  logic                 do_flush;

  // Flush only while nothing can be popped and the output slot is free or freeing.
  assign do_flush = flush && fifo_empty && (lane_q != '0) && (!valid_q || pk_ready);

  // Partial word: filled lanes pass through, stale lanes are zeroed.
  always_comb begin
    flush_word = '0;
    flush_keep = '0;
    for (int i = 0; i < int'(PACK) - 1; i++) begin
      if (CNTW'(i) < lane_q) begin
        flush_word[i*BITW +: BITW] = acc_q[i];
        flush_keep[i]              = 1'b1;
      end
    end
  end

  // Lane-valid mask tracks whichever word is loaded into the output register.
  always_comb begin
    keep_d = keep_q;
    if (fifo_pop && last_lane) begin
      keep_d = '1;
    end else if (do_flush) begin
      keep_d = flush_keep;
    end
  end

  // Lane-valid mask register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keep_q <= '0;
    end else begin
      keep_q <= keep_d;
    end
  end

  assign pk_keep = keep_q;
`endif

  // Next state for accumulator, lane counter and output register.
  always_comb begin
    acc_d   = acc_q;
    lane_d  = lane_q;
    data_d  = data_q;
    valid_d = valid_q;
    // Handshake frees the slot; a load below may refill it in the same cycle.
    if (valid_q && pk_ready) begin
      valid_d = 1'b0;
    end
    if (fifo_pop) begin
      if (last_lane) begin
        data_d  = full_word;
        valid_d = 1'b1;
        lane_d  = '0;
      end else begin
        for (int i = 0; i < int'(PACK) - 1; i++) begin
          if (CNTW'(i) == lane_q) begin
            acc_d[i] = fifo_data;
          end
        end
        lane_d = lane_q + CNTW'(1);
      end
    end
`ifdef FIFO_PACK_FLUSH_EN
    else if (do_flush) begin
      data_d  = flush_word;
      valid_d = 1'b1;
      lane_d  = '0;
    end
`endif
  end

  // State registers; reset discards any partial accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '{default: '0};
      lane_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign pk_data  = data_q;
  assign pk_valid = valid_q;
  assign lane_idx = lane_q;

endmodule

// File: doc/fifo_pack_rd.md
Name: fifo_pack_rd

Overview:
- Read-side drain stage that sits directly downstream of the team's synchronous FIFO (BITW data, full/empty status, asynchronous read of the head word).
- Pops narrow words from the FIFO and packs PACK consecutive words into one wide word.
- Presents the wide word on a valid/ready stream to the convolution datapath.
- Sustains one FIFO pop per cycle while the consumer keeps up.

Parameters:
- BITW, 8, width of one FIFO word.
- PACK, 4, FIFO words per packed output word; power of two, minimum 2.
- CNTW, $clog2(PACK), width of the lane counter (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fifo_data  input  BITW  FIFO head word; valid in the same cycle whenever fifo_empty is 0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_pop  output  1  pop strobe to FIFO; combinational.
- pk_data  output  BITW*PACK  packed word, registered.
- pk_valid  output  1  pk_data valid, registered.
- pk_ready  input  1  consumer accepts pk_data when pk_valid and pk_ready are both 1.
- lane_idx  output  CNTW  number of words held in the accumulator (0..PACK-1), registered.

Behaviour:
- Reset (rst low, any time, including mid-word):
  - pk_valid=0, pk_data=0, lane_idx=0, accumulator=0.
  - fifo_pop=0 while rst is low.
  - A partial accumulation is discarded.
- Storage: accumulator of PACK-1 lanes plus one output register. pk_data/pk_valid are driven only from the output register.
- Stall condition: stall = (lane_idx==PACK-1) && pk_valid && !pk_ready.
- Pop rule: fifo_pop = !fifo_empty && !stall.
  - Never pops when fifo_empty=1.
  - The FIFO word is consumed on the same edge that fifo_pop is high.
- On a pop with lane_idx<PACK-1:
  - fifo_data is written into accumulator lane lane_idx.
  - lane_idx increments.
- On a pop with lane_idx==PACK-1:
  - pk_data <= {fifo_data, acc lanes PACK-2..0}.
  - pk_valid <= 1, lane_idx <= 0.
- Lane order: the first word popped goes in bits [BITW-1:0]; the last word popped goes in the top lane.
- Output register:
  - Holds pk_data stable while pk_valid && !pk_ready.
  - On handshake with no new load: pk_valid <= 0 and pk_data keeps its value.
  - Handshake and new load in the same cycle: the new word replaces the old one and pk_valid stays 1. Back-to-back words are possible with no bubble.
- Throughput: after the pipeline fills, one packed word every PACK cycles when the FIFO never goes empty and pk_ready=1.
- Latency: last-lane pop edge to pk_valid high = 1 cycle (registered).
- FIFO empty mid-word: lane_idx holds and no pop occurs; packing resumes when the FIFO is non-empty.
- Stall: with the output register occupied and not ready, popping continues until PACK-1 lanes are filled, then fifo_pop=0 until pk_ready.
- lane_idx wraps PACK-1 -> 0 only on the completing pop; there is no other wrap.

Optional Feature:
- Macro: FIFO_PACK_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit) and output port pk_keep (PACK bits, registered, reset 0).
  - pk_keep bit i = 1 when lane i holds valid data. Full words give all ones.
  - flush is evaluated each cycle when fifo_empty=1, lane_idx>0 and the output register is free or freeing (!pk_valid || pk_ready). When these hold:
    - The partial word loads with unfilled lanes zeroed.
    - pk_keep = (1<<lane_idx)-1, pk_valid <= 1, lane_idx <= 0.
  - flush is ignored when lane_idx==0 or fifo_empty=0. Normal packing takes priority; the requester keeps flush high until lane_idx==0.
- Undefined: no flush or pk_keep ports; only full PACK-word outputs are produced.

Test Plan (BITW=8, PACK=4):
- FIFO holds 01,02,03,04, pk_ready=1 -> fifo_pop high 4 consecutive cycles; pk_data=32'h04030201, pk_valid high for 1 cycle, 1 cycle after the 4th pop.
- 12 words 01..0C streaming, pk_ready=1 -> outputs 04030201, 08070605, 0C0B0A09, each 4 cycles apart, no pop gaps.
- 8 words loaded, pk_ready=0 -> first word presented; 3 further pops then fifo_pop=0 with lane_idx=3; pk_data stable. Raise pk_ready -> next pop completes 08070605 the cycle after the handshake.
- Pop 01,02 then FIFO empty for 5 cycles, then 03,04 -> lane_idx=2 holds with no pops; output 04030201.
- rst low after 3 pops, then words 11..14 -> pk_valid=0 immediately, lane_idx=0; output 14131211 with no stale lanes.
- FIFO_PACK_FLUSH_EN defined: pop 0A,0B, FIFO empty, flush=1 -> pk_data=32'h00000B0A, pk_keep=4'b0011, lane_idx=0. flush with lane_idx=0 -> no output.
